// File: rtl/apb_timer_mc_pkg.sv
// Shared definitions for the multi-channel APB timer: register map,
// CTRL bit positions and the channel mode/state enumerations.
package apb_timer_mc_pkg;

    localparam logic [4:0] CTRL_OFF  = 5'h00;
    localparam logic [4:0] PRESC_OFF = 5'h04;
    localparam logic [4:0] COUNT_OFF = 5'h08;
    localparam logic [4:0] CMP_OFF   = 5'h0C;
    localparam logic [4:0] STAT_OFF  = 5'h10;

    localparam logic [8:0] CH_STRIDE     = 9'h020;
    localparam logic [8:0] IRQ_STAT_ADDR = 9'h100;
    localparam int         CH_SHIFT      = $clog2(CH_STRIDE);

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;
    localparam int CTRL_IE_BIT   = 2;
    localparam int STAT_EXP_BIT  = 0;

    typedef enum logic {ONE_SHOT = 1'b0, PERIODIC = 1'b1} mode_e;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;

endpackage

// File: rtl/apb_timer_mc_if.sv
// APB slave bus bundle for the timer; the bench drives the master side.
interface apb_timer_mc_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_mc_timer_channel.sv
// One timer channel: registers, prescaler, counter and IDLE/RUN FSM.
// The top hands it a qualified write strobe and a word-aligned offset.
module timer_channel
    import apb_timer_mc_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [4:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    ch_state_e              state, state_next;
    mode_e                  mode;
    logic                   ie;
    logic                   exp;
    logic [PRESC_WIDTH-1:0] presc, pc;
    logic [CNT_WIDTH-1:0]   count, cmp;
    logic                   wr_ctrl, wr_presc, wr_count, wr_cmp, wr_stat;
    logic                   tick, match;
    logic                   unused;

    assign wr_ctrl  = wr && (off == CTRL_OFF);
    assign wr_presc = wr && (off == PRESC_OFF);
    assign wr_count = wr && (off == COUNT_OFF);
    assign wr_cmp   = wr && (off == CMP_OFF);
    assign wr_stat  = wr && (off == STAT_OFF);

    assign tick  = (state == RUN) && (pc == presc);
    assign match = tick && (count == cmp);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (wr_ctrl) state_next = wdata[CTRL_EN_BIT] ? RUN : IDLE;
        // A one-shot expiry clears EN even against a same-cycle EN=1 write.
        if (match && (mode == ONE_SHOT)) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode  <= ONE_SHOT;
            ie    <= 1'b0;
            exp   <= 1'b0;
            presc <= '0;
            pc    <= '0;
            count <= '0;
            cmp   <= '0;
        end else begin
            if (wr_ctrl) begin
                mode <= mode_e'(wdata[CTRL_MODE_BIT]);
                ie   <= wdata[CTRL_IE_BIT];
            end
            if (wr_presc) presc <= wdata[PRESC_WIDTH-1:0];
            if (wr_cmp)   cmp   <= wdata[CNT_WIDTH-1:0];

            // pc only runs while staying in RUN; entering or leaving RUN parks it at 0.
            if ((state != RUN) || (state_next != RUN) || tick) pc <= '0;
            else                                              pc <= pc + PRESC_WIDTH'(1);

            if (wr_count)                     count <= wdata[CNT_WIDTH-1:0];
            else if (match && mode == PERIODIC) count <= '0;
            else if (tick && !match)          count <= count + CNT_WIDTH'(1);

            if (match)                             exp <= 1'b1;
            else if (wr_stat && wdata[STAT_EXP_BIT]) exp <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            CTRL_OFF: begin
                rdata[CTRL_EN_BIT]   = (state == RUN);
                rdata[CTRL_MODE_BIT] = (mode == PERIODIC);
                rdata[CTRL_IE_BIT]   = ie;
            end
            PRESC_OFF: rdata = 32'(presc);
            COUNT_OFF: rdata = 32'(count);
            CMP_OFF:   rdata = 32'(cmp);
            STAT_OFF:  rdata[STAT_EXP_BIT] = exp;
            default:   rdata = '0;
        endcase
    end

    assign irq    = exp & ie;
    assign unused = ^wdata;

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer top: address decode, read mux and IRQ merge
// around NUM_CH independent timer_channel instances.
module apb_timer_mc
    import apb_timer_mc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int PRESC_WIDTH    = 12
) (
    input  logic              HCLK,
    input  logic              HRESET,
    apb_timer_mc_if.slave     apb,
    output logic [NUM_CH-1:0] irq_o,
    output logic              irq_any_o
);

    logic [8:0]  addr;
    logic [2:0]  ch_idx;
    logic [4:0]  off;
    logic        acc, wr, rd;
    logic        is_irq_stat, is_ch;
    logic [31:0] ch_rdata [NUM_CH];
    logic [31:0] rdata_sel;
    logic        unused;

    assign addr   = apb.PADDR[8:0];
    assign ch_idx = addr[CH_SHIFT +: 3];
    assign off    = {addr[CH_SHIFT-1:2], 2'b00};

    assign acc = apb.PSEL & apb.PENABLE;
    assign wr  = acc & apb.PWRITE;
    assign rd  = acc & ~apb.PWRITE;

    assign is_irq_stat = ({addr[8:2], 2'b00} == IRQ_STAT_ADDR);
    assign is_ch       = !addr[8] && (32'(ch_idx) < NUM_CH) && (off <= STAT_OFF);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        timer_channel #(
            .CNT_WIDTH  (CNT_WIDTH),
            .PRESC_WIDTH(PRESC_WIDTH)
        ) u_ch (
            .clk  (HCLK),
            .rst  (HRESET),
            .wr   (wr && is_ch && (ch_idx == 3'(c))),
            .off  (off),
            .wdata(apb.PWDATA),
            .rdata(ch_rdata[c]),
            .irq  (irq_o[c])
        );
    end

    always_comb begin
        rdata_sel = '0;
        if (is_irq_stat) begin
            rdata_sel = 32'(irq_o);
        end else if (is_ch) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 3'(c)) rdata_sel = ch_rdata[c];
            end
        end
    end

    // IRQ_STAT writes are accepted silently; only unmapped addresses error.
    assign apb.PRDATA  = rd ? rdata_sel : '0;
    assign apb.PSLVERR = acc & ~(is_ch | is_irq_stat);
    assign apb.PREADY  = 1'b1;

    assign irq_any_o = |irq_o;
    assign unused    = ^{apb.PADDR[APB_ADDR_WIDTH-1:9], addr[1:0]};

endmodule

// File: tb/tb_apb_timer_mc.sv
// Scoreboard bench for apb_timer_mc: the stimulus pushes the expected bus response
// per access cycle, and a monitor pops and compares on every APB access phase.
module tb_apb_timer_mc;

    localparam int NCH = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_irq;
        logic [3:0]  irq;
        string       name;
    } exp_t;

    logic           HCLK = 1'b0;
    logic           HRESET;
    logic [NCH-1:0] irq_o;
    logic           irq_any_o;

    exp_t sb[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    apb_timer_mc_if #(.ADDR_WIDTH(12)) bus ();

    apb_timer_mc #(
        .APB_ADDR_WIDTH(12),
        .NUM_CH        (NCH),
        .CNT_WIDTH     (8),
        .PRESC_WIDTH   (12)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .apb      (bus),
        .irq_o    (irq_o),
        .irq_any_o(irq_any_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ch_addr(input int c, input logic [4:0] off);
        return 12'(c * 32) | 12'(off);
    endfunction

    task automatic push(input logic [31:0] data, input logic err, input logic chk,
                        input logic [3:0] irq, input string name);
        exp_t e;
        e.data = data; e.err = err; e.chk_irq = chk; e.irq = irq; e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    // Setup cycle followed by n consecutive access cycles on one address.
    task automatic read_stream(input logic [11:0] addr, input int n);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1;
        repeat (n) begin @(posedge HCLK); #1; end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] data, input logic err,
                      input logic chk, input logic [3:0] irq, input string name);
        push(data, err, chk, irq, name);
        read_stream(addr, 1);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic err,
                      input string name);
        push(32'h0, err, 1'b0, 4'h0, name);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = addr; bus.PWDATA = data;
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge HCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    // Monitor: one scoreboard entry per access-phase cycle, sampled mid-cycle.
    initial forever begin
        @(negedge HCLK);
        if (!HRESET && bus.PSEL && bus.PENABLE) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: access seen with no expected entry at %0t", $time);
            end else begin
                cur = sb.pop_front();
                check({cur.name, "_prdata"}, bus.PRDATA, cur.data);
                check({cur.name, "_pslverr"}, 32'(bus.PSLVERR), 32'(cur.err));
                check({cur.name, "_pready"}, 32'(bus.PREADY), 32'd1);
                if (cur.chk_irq) begin
                    check({cur.name, "_irq"}, 32'(irq_o), 32'(cur.irq));
                    check({cur.name, "_irq_any"}, 32'(irq_any_o), 32'(|cur.irq));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0;  bus.PWDATA = '0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state: every register and IRQ_STAT read 0, no interrupts.
        for (int c = 0; c < NCH; c++)
            for (int o = 0; o < 5; o++)
                rd(ch_addr(c, 5'(o * 4)), 32'h0, 1'b0, 1'b1, 4'h0, "rst_reg");
        rd(12'h100, 32'h0, 1'b0, 1'b1, 4'h0, "rst_irq_stat");

        // Periodic ch0: PRESC=1, CMP=3 -> COUNT steps every 2 cycles, expiry every 8.
        wr(ch_addr(0, 5'h04), 32'd1, 1'b0, "per_wr_presc");
        wr(ch_addr(0, 5'h0C), 32'd3, 1'b0, "per_wr_cmp");
        wr(ch_addr(0, 5'h00), 32'h7, 1'b0, "per_wr_ctrl");
        for (int k = 1; k <= 17; k++)
            push(32'((k / 2) % 4), 1'b0, 1'b1, (k >= 8) ? 4'b0001 : 4'b0000, "per_count");
        read_stream(ch_addr(0, 5'h08), 17);
        wr(ch_addr(0, 5'h00), 32'h4, 1'b0, "per_stop");
        rd(ch_addr(0, 5'h00), 32'h4, 1'b0, 1'b1, 4'b0001, "per_ctrl");
        rd(ch_addr(0, 5'h10), 32'h1, 1'b0, 1'b1, 4'b0001, "per_stat");
        wr(ch_addr(0, 5'h10), 32'h1, 1'b0, "per_w1c");
        rd(ch_addr(0, 5'h10), 32'h0, 1'b0, 1'b1, 4'b0000, "per_stat_clr");

        // One-shot ch1: PRESC=0, CMP=5 -> expiry on the 6th tick, COUNT parks at 5.
        wr(ch_addr(1, 5'h04), 32'd0, 1'b0, "os_wr_presc");
        wr(ch_addr(1, 5'h0C), 32'd5, 1'b0, "os_wr_cmp");
        wr(ch_addr(1, 5'h00), 32'h5, 1'b0, "os_wr_ctrl");
        for (int k = 1; k <= 8; k++)
            push((k < 5) ? 32'(k) : 32'd5, 1'b0, 1'b1, (k >= 6) ? 4'b0010 : 4'b0000, "os_count");
        read_stream(ch_addr(1, 5'h08), 8);
        rd(ch_addr(1, 5'h00), 32'h4, 1'b0, 1'b1, 4'b0010, "os_ctrl");
        rd(ch_addr(1, 5'h08), 32'h5, 1'b0, 1'b1, 4'b0010, "os_count_hold");
        wr(ch_addr(1, 5'h10), 32'h1, 1'b0, "os_w1c");
        rd(12'h100, 32'h0, 1'b0, 1'b1, 4'b0000, "os_irq_clr");

        // ch2 periodic, CMP=3, PRESC=0: expiries at 4 and 8 edges after enable;
        // the W1C commits on the second one and must lose.
        wr(ch_addr(2, 5'h0C), 32'd3, 1'b0, "sim_wr_cmp");
        wr(ch_addr(2, 5'h00), 32'h3, 1'b0, "sim_wr_ctrl");
        idle(6);
        wr(ch_addr(2, 5'h10), 32'h1, 1'b0, "sim_w1c");
        rd(ch_addr(2, 5'h10), 32'h1, 1'b0, 1'b1, 4'b0000, "sim_exp_kept");
        wr(ch_addr(2, 5'h00), 32'h0, 1'b0, "sim_stop");

        // ch3 one-shot running every cycle; a COUNT write on a tick edge wins.
        wr(ch_addr(3, 5'h0C), 32'hFF, 1'b0, "cw_wr_cmp");
        wr(ch_addr(3, 5'h00), 32'h1, 1'b0, "cw_wr_ctrl");
        wr(ch_addr(3, 5'h08), 32'h40, 1'b0, "cw_wr_count");
        push(32'h41, 1'b0, 1'b0, 4'h0, "cw_count");
        push(32'h42, 1'b0, 1'b0, 4'h0, "cw_count");
        read_stream(ch_addr(3, 5'h08), 2);
        wr(ch_addr(3, 5'h00), 32'h0, 1'b0, "cw_stop");

        // 8-bit wrap on ch3: 0xFE -> 0xFF -> 0x00 -> 0x01 -> 0x02 (match) -> 0x00.
        wr(ch_addr(3, 5'h08), 32'hFE, 1'b0, "wrap_wr_count");
        wr(ch_addr(3, 5'h0C), 32'h02, 1'b0, "wrap_wr_cmp");
        wr(ch_addr(3, 5'h00), 32'h7, 1'b0, "wrap_wr_ctrl");
        push(32'hFF, 1'b0, 1'b1, 4'b0000, "wrap_count");
        push(32'h00, 1'b0, 1'b1, 4'b0000, "wrap_count");
        push(32'h01, 1'b0, 1'b1, 4'b0000, "wrap_count");
        push(32'h02, 1'b0, 1'b1, 4'b0000, "wrap_count");
        push(32'h00, 1'b0, 1'b1, 4'b1000, "wrap_count");
        push(32'h01, 1'b0, 1'b1, 4'b1000, "wrap_count");
        read_stream(ch_addr(3, 5'h08), 6);

        // Unmapped accesses error, read 0 and leave registers untouched.
        rd(12'h014, 32'h0, 1'b1, 1'b1, 4'b1000, "unm_rd_014");
        rd(12'h1F0, 32'h0, 1'b1, 1'b1, 4'b1000, "unm_rd_1f0");
        rd(12'h080, 32'h0, 1'b1, 1'b1, 4'b1000, "unm_rd_ch4");
        wr(12'h014, 32'hFFFF_FFFF, 1'b1, "unm_wr_014");
        wr(12'h08C, 32'hFFFF_FFFF, 1'b1, "unm_wr_ch4");
        rd(ch_addr(0, 5'h04), 32'd1, 1'b0, 1'b0, 4'h0, "unm_ch0_presc");
        rd(ch_addr(0, 5'h0C), 32'd3, 1'b0, 1'b0, 4'h0, "unm_ch0_cmp");
        rd(ch_addr(0, 5'h00), 32'h4, 1'b0, 1'b0, 4'h0, "unm_ch0_ctrl");
        wr(12'h100, 32'hF, 1'b0, "irqstat_wr");
        rd(12'h100, 32'h8, 1'b0, 1'b1, 4'b1000, "irqstat_rd");

        // Reset mid-operation with ch3 running and its interrupt pending.
        HRESET = 1'b1;
        idle(1);
        HRESET = 1'b0;
        rd(12'h100, 32'h0, 1'b0, 1'b1, 4'b0000, "mrst_irq_stat");
        rd(ch_addr(3, 5'h00), 32'h0, 1'b0, 1'b1, 4'b0000, "mrst_ctrl");
        rd(ch_addr(3, 5'h08), 32'h0, 1'b0, 1'b1, 4'b0000, "mrst_count");
        rd(ch_addr(0, 5'h04), 32'h0, 1'b0, 1'b1, 4'b0000, "mrst_presc");

        idle(2);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
